// File: rtl/pipeline_arbiter_pkg.sv
// Shared widths and operand packing for the two-requester pipelined-datapath arbiter.
package pipeline_arbiter_pkg;

    localparam int OP_W         = 3;
    localparam int RES_W        = 8;
    localparam int OPS_W        = 4 * OP_W;
    localparam int OP_A_LSB     = 9;
    localparam int OP_B_LSB     = 6;
    localparam int OP_C_LSB     = 3;
    localparam int OP_D_LSB     = 0;
    localparam int PIPE_LAT_DEF = 2;
    localparam int CNT_W        = 4;

    function automatic logic [OP_W-1:0] op_field(input logic [OPS_W-1:0] ops, input int lsb);
        return ops[lsb +: OP_W];
    endfunction

endpackage

// File: rtl/pipeline_arbiter_tag_shift.sv
// Valid/id delay line that follows each issued operation through the shared datapath.
module tag_shift #(
    parameter int DEPTH = 3,
    parameter int ID_W  = 1
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            vld_i,
    input  logic [ID_W-1:0] id_i,
    output logic            vld_o,
    output logic [ID_W-1:0] id_o
);

    logic [DEPTH-1:0]           vld_q, vld_d;
    logic [DEPTH-1:0][ID_W-1:0] id_q, id_d;

    always_comb begin
        vld_d = {vld_q[DEPTH-2:0], vld_i};
        id_d  = {id_q[DEPTH-2:0], id_i};
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign id_o  = id_q[DEPTH-1];

endmodule

// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter feeding a fixed-latency shared datapath and routing results back by tag.
module pipeline_arbiter
    import pipeline_arbiter_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [OPS_W-1:0] req0_ops,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OPS_W-1:0] req1_ops,
    output logic             req1_ready,
    output logic [OP_W-1:0]  pipe_a,
    output logic [OP_W-1:0]  pipe_b,
    output logic [OP_W-1:0]  pipe_c,
    output logic [OP_W-1:0]  pipe_d,
    input  logic [RES_W-1:0] pipe_y,
    output logic             rsp0_valid,
    output logic [RES_W-1:0] rsp0_y,
    output logic             rsp1_valid,
    output logic [RES_W-1:0] rsp1_y,
    output logic [CNT_W-1:0] in_flight,
    output logic             idle
);

    logic             last_grant_q, last_grant_d;
    logic [OPS_W-1:0] ops_q, ops_d;
    logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [RES_W-1:0] rsp0_y_q, rsp0_y_d, rsp1_y_q, rsp1_y_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic             grant0, grant1, issue, rsp_any;
    logic             fin_vld;
    logic [0:0]       fin_id;

    // last_grant_q==1 means requester 1 was served last, so requester 0 wins a tie
    always_comb begin
        grant0 = !reset && req0_valid && (!req1_valid || last_grant_q);
        grant1 = !reset && req1_valid && (!req0_valid || !last_grant_q);
        issue  = grant0 || grant1;
        rsp_any = rsp0_valid_q || rsp1_valid_q;

        last_grant_d = issue ? grant1 : last_grant_q;
        ops_d        = grant1 ? req1_ops : (grant0 ? req0_ops : '0);

        rsp0_valid_d = fin_vld && (fin_id == 1'b0);
        rsp1_valid_d = fin_vld && (fin_id == 1'b1);
        rsp0_y_d     = rsp0_valid_d ? pipe_y : rsp0_y_q;
        rsp1_y_d     = rsp1_valid_d ? pipe_y : rsp1_y_q;

        in_flight_d = in_flight_q;
        if (issue && !rsp_any && in_flight_q != '1)
            in_flight_d = in_flight_q + CNT_W'(1);
        else if (!issue && rsp_any && in_flight_q != '0)
            in_flight_d = in_flight_q - CNT_W'(1);
    end

    tag_shift #(
        .DEPTH(PIPE_LAT + 1),
        .ID_W (1)
    ) u_tag_shift (
        .clock_i(clock),
        .reset_i(reset),
        .vld_i  (issue),
        .id_i   (grant1),
        .vld_o  (fin_vld),
        .id_o   (fin_id)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            ops_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_y_q     <= '0;
            rsp1_y_q     <= '0;
            in_flight_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            ops_q        <= ops_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_y_q     <= rsp0_y_d;
            rsp1_y_q     <= rsp1_y_d;
            in_flight_q  <= in_flight_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign pipe_a     = op_field(ops_q, OP_A_LSB);
    assign pipe_b     = op_field(ops_q, OP_B_LSB);
    assign pipe_c     = op_field(ops_q, OP_C_LSB);
    assign pipe_d     = op_field(ops_q, OP_D_LSB);
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_y     = rsp0_y_q;
    assign rsp1_y     = rsp1_y_q;
    assign in_flight  = in_flight_q;
    assign idle       = (in_flight_q == '0) && !req0_valid && !req1_valid;

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed bench for pipeline_arbiter with a two-cycle datapath stub computing {2'b00,a,b}.
module tb_pipeline_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [11:0] req0_ops = '0, req1_ops = '0;
    logic        req0_ready, req1_ready;
    logic [2:0]  pipe_a, pipe_b, pipe_c, pipe_d;
    logic [7:0]  pipe_y = '0;
    logic [7:0]  stub_d1 = '0;
    logic        rsp0_valid, rsp1_valid;
    logic [7:0]  rsp0_y, rsp1_y;
    logic [3:0]  in_flight;
    logic        idle;

    int passed = 0;
    int total  = 0;

    pipeline_arbiter #(.PIPE_LAT(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_ops  (req0_ops),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_ops  (req1_ops),
        .req1_ready(req1_ready),
        .pipe_a    (pipe_a),
        .pipe_b    (pipe_b),
        .pipe_c    (pipe_c),
        .pipe_d    (pipe_d),
        .pipe_y    (pipe_y),
        .rsp0_valid(rsp0_valid),
        .rsp0_y    (rsp0_y),
        .rsp1_valid(rsp1_valid),
        .rsp1_y    (rsp1_y),
        .in_flight (in_flight),
        .idle      (idle)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        stub_d1 <= {2'b00, pipe_a, pipe_b};
        pipe_y  <= stub_d1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rst, input logic v0, input logic [11:0] o0,
                         input logic v1, input logic [11:0] o1);
        reset      = rst;
        req0_valid = v0;
        req0_ops   = o0;
        req1_valid = v1;
        req1_ops   = o1;
        #1;
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0b expected=%0b", name, obs, exp);
    endtask

    task automatic chk8(input string name, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    localparam logic [11:0] OPS_1234 = 12'h29C; // a=1 b=2 c=3 d=4 -> y=0A
    localparam logic [11:0] OPS_11   = 12'h240; // a=1 b=1 -> y=09
    localparam logic [11:0] OPS_22   = 12'h480; // a=2 b=2 -> y=12
    localparam logic [11:0] OPS_35   = 12'h740; // a=3 b=5 -> y=1D
    localparam logic [11:0] OPS_77   = 12'hFC0; // a=7 b=7 -> y=3F

    initial begin
        // reset state, ready held low during reset
        step();
        drive(1'b1, 1'b1, OPS_1234, 1'b1, OPS_22);
        chk1("rst_r0_ready", req0_ready, 1'b0);
        chk1("rst_r1_ready", req1_ready, 1'b0);
        step();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        chk8("rst_in_flight", 8'(in_flight), 8'd0);
        chk8("rst_pipe_a", 8'(pipe_a), 8'd0);
        chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk8("rst_rsp0_y", rsp0_y, 8'd0);
        chk8("rst_rsp1_y", rsp1_y, 8'd0);
        step();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        chk1("rst_idle", idle, 1'b1);

        // single request from requester 0
        step();
        drive(1'b0, 1'b1, OPS_1234, 1'b0, '0);
        chk1("s_r0_ready", req0_ready, 1'b1);
        chk1("s_r1_ready", req1_ready, 1'b0);
        chk1("s_idle_busy", idle, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        chk8("s_pipe_a", 8'(pipe_a), 8'd1);
        chk8("s_pipe_b", 8'(pipe_b), 8'd2);
        chk8("s_pipe_c", 8'(pipe_c), 8'd3);
        chk8("s_pipe_d", 8'(pipe_d), 8'd4);
        chk8("s_in_flight1", 8'(in_flight), 8'd1);
        step();
        chk8("s_pipe_a_clr", 8'(pipe_a), 8'd0);
        chk1("s_rsp0_early1", rsp0_valid, 1'b0);
        step();
        chk1("s_rsp0_early2", rsp0_valid, 1'b0);
        step();
        chk1("s_rsp0_valid", rsp0_valid, 1'b1);
        chk8("s_rsp0_y", rsp0_y, 8'h0A);
        chk1("s_rsp1_quiet", rsp1_valid, 1'b0);
        chk8("s_in_flight_at_rsp", 8'(in_flight), 8'd1);
        step();
        chk1("s_rsp0_pulse_end", rsp0_valid, 1'b0);
        chk8("s_rsp0_y_hold", rsp0_y, 8'h0A);
        chk8("s_in_flight0", 8'(in_flight), 8'd0);
        chk1("s_idle", idle, 1'b1);

        // fresh reset so requester 0 wins first contention
        step();
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        step();
        drive(1'b0, 1'b0, '0, 1'b0, '0);

        // both valid: alternating grants and responses
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b0, 1'b1, OPS_11, 1'b1, OPS_22);
            chk1("rr_r0_ready", req0_ready, (i % 2) == 0);
            chk1("rr_r1_ready", req1_ready, (i % 2) == 1);
            chk8("rr_in_flight_fill", 8'(in_flight), 8'(i));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            chk1("rr_rsp0_valid", rsp0_valid, (k % 2) == 0);
            chk1("rr_rsp1_valid", rsp1_valid, (k % 2) == 1);
            if ((k % 2) == 0) chk8("rr_rsp0_y", rsp0_y, 8'h09);
            else              chk8("rr_rsp1_y", rsp1_y, 8'h12);
            chk8("rr_in_flight_drain", 8'(in_flight), 8'(4 - k));
        end
        step();
        chk8("rr_in_flight0", 8'(in_flight), 8'd0);
        chk1("rr_idle", idle, 1'b1);
        chk8("rr_rsp0_y_hold", rsp0_y, 8'h09);
        chk8("rr_rsp1_y_hold", rsp1_y, 8'h12);

        // requester 1 alone, four back-to-back issues
        for (int i = 0; i < 4; i++) begin
            step();
            drive(1'b0, 1'b0, '0, 1'b1, OPS_35);
            chk1("b2b_r1_ready", req1_ready, 1'b1);
            chk1("b2b_r0_ready", req0_ready, 1'b0);
            chk8("b2b_in_flight_fill", 8'(in_flight), 8'(i));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            chk1("b2b_rsp1_valid", rsp1_valid, 1'b1);
            chk8("b2b_rsp1_y", rsp1_y, 8'h1D);
            chk1("b2b_rsp0_quiet", rsp0_valid, 1'b0);
            chk8("b2b_in_flight_drain", 8'(in_flight), 8'(4 - k));
        end
        step();
        chk1("b2b_rsp1_end", rsp1_valid, 1'b0);
        chk1("b2b_idle", idle, 1'b1);

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b0, 1'b1, OPS_1234, 1'b0, '0);
        end
        step();
        drive(1'b1, 1'b1, OPS_1234, 1'b1, OPS_77);
        chk8("mr_in_flight3", 8'(in_flight), 8'd3);
        chk1("mr_r0_ready_rst", req0_ready, 1'b0);
        chk1("mr_r1_ready_rst", req1_ready, 1'b0);
        step();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        chk8("mr_in_flight0", 8'(in_flight), 8'd0);
        chk8("mr_pipe_a", 8'(pipe_a), 8'd0);
        chk1("mr_rsp0_valid", rsp0_valid, 1'b0);
        chk8("mr_rsp0_y", rsp0_y, 8'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk1("mr_no_rsp0", rsp0_valid, 1'b0);
            chk1("mr_no_rsp1", rsp1_valid, 1'b0);
            chk8("mr_in_flight_stay0", 8'(in_flight), 8'd0);
        end

        // req0 held, req1 valid in two cycles: first contention to req0, second to req1
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b0, 1'b1, OPS_1234, (i == 0) || (i == 2), OPS_77);
            chk1("hold_r0_ready", req0_ready, i != 2);
            chk1("hold_r1_ready", req1_ready, i == 2);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            drive(1'b0, 1'b0, '0, 1'b0, '0);
            chk1("hold_rsp0_valid", rsp0_valid, k != 2);
            chk1("hold_rsp1_valid", rsp1_valid, k == 2);
            if (k == 2) chk8("hold_rsp1_y", rsp1_y, 8'h3F);
            else        chk8("hold_rsp0_y", rsp0_y, 8'h0A);
        end
        step();
        chk8("hold_in_flight0", 8'(in_flight), 8'd0);
        chk1("hold_idle", idle, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
